header_loader: RTL and testbench
================================

Name: header_loader

Overview:
- Write-side front end for the 80-byte block-header store.
- Takes a byte stream from the USB receive path over a valid/ready handshake.
- Assigns sequential byte addresses 0..79 and drives the store's write-enable, data and address inputs.
- Tells the mining controller when a complete header is loaded. Handles frame restart and stalled-stream timeout.

Parameters:
- HEADER_BYTES, 80, number of bytes in one header frame; address range 0..HEADER_BYTES-1.
- ADDR_W, 7, width of the byte address and byte count.
- TIMEOUT_CYCLES, 1024, maximum number of cycles between accepted bytes while loading before the frame is aborted.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse marking the start of a new header frame.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  incoming header byte, in byte 0 first order.
- rx_ready  out  1  loader accepts a byte this cycle. Combinational: (state==LOAD) && !start.
- header_ack  in  1  mining controller has taken the header; releases DONE.
- o_data_en  out  1  registered one-cycle write strobe to the header store.
- o_data  out  8  registered byte to write.
- o_data_sel  out  ADDR_W  registered byte address of o_data.
- byte_count  out  ADDR_W  bytes accepted in the current frame.
- header_ready  out  1  level: all HEADER_BYTES bytes have been written.
- load_error  out  1  level: the last frame was aborted by timeout.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; o_data_en=0, o_data=0, o_data_sel=0, byte_count=0, header_ready=0, load_error=0; timeout counter=0. Reset mid-frame abandons the frame and issues no further strobes.
- A handshake completes in a cycle where rx_valid && rx_ready.
- States:
  - IDLE: rx_ready=0. start moves to LOAD with byte_count=0, timeout counter=0, load_error=0.
  - LOAD: rx_ready=1 unless start is high.
    - On a handshake, the next cycle has o_data_en=1, o_data=rx_data, o_data_sel=byte_count (the old value). byte_count increments and the timeout counter clears.
    - If the accepted byte is address HEADER_BYTES-1, move to DONE.
    - Cycles without a handshake increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without a handshake, move to ERROR.
    - start in LOAD restarts the frame: byte_count=0, timeout counter=0, no strobe. No byte is accepted that cycle, because rx_ready is low.
  - DONE: rx_ready=0. header_ready is registered and rises on the cycle after the final o_data_en, so the store already holds byte 79 when header_ready is first seen. Latency from the byte-79 handshake to header_ready=1 is 2 cycles.
    - header_ack clears header_ready next cycle and moves to IDLE with byte_count=0.
    - start in DONE is ignored; the header must not be overwritten before it is acknowledged.
    - header_ack in any other state is ignored.
  - ERROR: rx_ready=0, load_error=1. byte_count holds the partial count.
    - start moves to LOAD: load_error clears next cycle and byte_count=0.
    - Bytes already written to the store are left as-is; the next full frame overwrites them.
- o_data_en is high for exactly one cycle per accepted byte and never otherwise.
- At most HEADER_BYTES strobes are issued per frame. o_data_sel never exceeds HEADER_BYTES-1.
- o_data and o_data_sel hold their last value when o_data_en=0.
- byte_count saturates at HEADER_BYTES; there is no wrap.
- The timeout counter is wide enough for TIMEOUT_CYCLES and runs only in LOAD.

Test Plan:
- Normal load:
  - Stimulus: reset, start, then 80 back-to-back bytes with value = address XOR 0xA5.
  - Required: 80 strobes with o_data_sel 0..79 and matching o_data; header_ready=1 exactly 2 cycles after the last handshake; byte_count=80.
- Gapped stream and ack:
  - Stimulus: bytes with random 0-20 cycle gaps (each below TIMEOUT_CYCLES); then header_ack.
  - Required: identical strobe sequence; no load_error; header_ready falls the cycle after ack; state returns to IDLE with byte_count=0.
- Timeout:
  - Stimulus: 10 bytes, then rx_valid low for 1024 cycles.
  - Required: load_error=1 and rx_ready=0, no further strobes, byte_count=10.
  - Then start and a full frame: load_error clears and a normal load completes.
- Restart mid-frame:
  - Stimulus: 30 bytes, then start asserted together with rx_valid.
  - Required: rx_ready=0 that cycle; the next byte is strobed at o_data_sel=0.
  - Also in DONE: start is ignored; header_ready stays 1 and there are no strobes.
- Idle and reset:
  - Stimulus: rx_valid=1 in IDLE.
  - Required: rx_ready=0, no strobes.
  - Stimulus: rst during LOAD after 40 bytes.
  - Required: all outputs return to reset values next cycle; there are no further strobes.

Source files
------------

// File: rtl/header_loader_if.sv
// Byte-stream and header-store signals between the USB receive path, the
// header loader and the mining controller.
interface header_loader_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              header_ack;
    logic              o_data_en;
    logic [7:0]        o_data;
    logic [ADDR_W-1:0] o_data_sel;
    logic [ADDR_W-1:0] byte_count;
    logic              header_ready;
    logic              load_error;

    modport master (
        output start, rx_valid, rx_data, header_ack,
        input  rx_ready, o_data_en, o_data, o_data_sel, byte_count,
               header_ready, load_error
    );

    modport slave (
        input  start, rx_valid, rx_data, header_ack,
        output rx_ready, o_data_en, o_data, o_data_sel, byte_count,
               header_ready, load_error
    );
endinterface

// File: rtl/header_loader.sv
// Write-side front end of the 80-byte block-header store: numbers incoming
// bytes, strobes them into the store and reports frame completion or timeout.
module header_loader #(
    parameter int HEADER_BYTES   = 80,
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    header_loader_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timeout_count;
    logic            handshake;
    logic            last_byte;
    logic            timeout_hit;

    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b0;
        handshake    = 1'b0;
        last_byte    = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = LOAD;
            end
            LOAD: begin
                bus.rx_ready = !bus.start;
                handshake    = bus.rx_valid && !bus.start;
                last_byte    = handshake && (bus.byte_count == ADDR_W'(HEADER_BYTES - 1));
                timeout_hit  = !bus.start && !handshake &&
                               (timeout_count == TW'(TIMEOUT_CYCLES - 1));
                if (last_byte)        state_next = DONE;
                else if (timeout_hit) state_next = ERROR;
            end
            DONE: begin
                if (bus.header_ack) state_next = IDLE;
            end
            ERROR: begin
                if (bus.start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobe, address and data are registered so the store sees them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            timeout_count    <= '0;
            bus.o_data_en    <= 1'b0;
            bus.o_data       <= '0;
            bus.o_data_sel   <= '0;
            bus.byte_count   <= '0;
            bus.header_ready <= 1'b0;
            bus.load_error   <= 1'b0;
        end else begin
            state         <= state_next;
            bus.o_data_en <= handshake;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.byte_count <= '0;
                        timeout_count  <= '0;
                        bus.load_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.start) begin
                        bus.byte_count <= '0;
                        timeout_count  <= '0;
                    end else if (handshake) begin
                        bus.o_data     <= bus.rx_data;
                        bus.o_data_sel <= bus.byte_count;
                        if (bus.byte_count != ADDR_W'(HEADER_BYTES))
                            bus.byte_count <= bus.byte_count + ADDR_W'(1);
                        timeout_count <= '0;
                    end else if (timeout_hit) begin
                        bus.load_error <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + TW'(1);
                    end
                end
                // header_ready rises one cycle after the final strobe lands.
                DONE: begin
                    if (bus.header_ack) begin
                        bus.header_ready <= 1'b0;
                        bus.byte_count   <= '0;
                    end else begin
                        bus.header_ready <= 1'b1;
                    end
                end
                ERROR: begin
                    if (bus.start) begin
                        bus.load_error <= 1'b0;
                        bus.byte_count <= '0;
                        timeout_count  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_header_loader.sv
// Directed self-checking bench for header_loader: full, gapped, timed-out,
// restarted and reset frames with strobes logged and compared per byte.
module tb_header_loader;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    header_loader_if #(.ADDR_W(7)) bus();

    header_loader #(
        .HEADER_BYTES(80),
        .ADDR_W(7),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int         strobe_n = 0;
    logic [7:0] log_data [0:1023];
    logic [6:0] log_sel  [0:1023];

    // Record every store write just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (bus.o_data_en === 1'b1) begin
            if (strobe_n < 1024) begin
                log_data[strobe_n] = bus.o_data;
                log_sel[strobe_n]  = bus.o_data_sel;
            end
            strobe_n++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offer one byte after some idle cycles; returns just before the accepting edge.
    task automatic applyStimulus(input logic [7:0] value, input int gap);
        int budget;
        repeat (gap) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = value;
        #1;
        budget = 0;
        while (bus.rx_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (bus.rx_ready !== 1'b1) checkOutput("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic sendBytes(input int first, input int count, input bit gapped);
        for (int i = first; i < first + count; i++)
            applyStimulus(8'(i) ^ 8'hA5, gapped ? (i * 7 + 3) % 21 : 0);
    endtask

    task automatic checkFrame(input int base, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            checkOutput("strobe_sel",  32'(log_sel[base + i]),  32'(first + i));
            checkOutput("strobe_data", 32'(log_data[base + i]), 32'(8'(first + i) ^ 8'hA5));
        end
    endtask

    task automatic loadFullFrame(input bit gapped);
        int base;
        base = strobe_n;
        pulseStart();
        sendBytes(0, 80, gapped);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("last_strobe_en",  32'(bus.o_data_en), 32'd1);
        checkOutput("last_strobe_sel", 32'(bus.o_data_sel), 32'd79);
        checkOutput("ready_not_early", 32'(bus.header_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_latency2", 32'(bus.header_ready), 32'd1);
        checkOutput("done_count",     32'(bus.byte_count), 32'd80);
        checkOutput("done_no_error",  32'(bus.load_error), 32'd0);
        checkOutput("frame_strobes",  32'(strobe_n - base), 32'd80);
        checkFrame(base, 0, 80);
    endtask

    task automatic ackHeader();
        @(negedge clk);
        bus.header_ack = 1'b1;
        @(negedge clk);
        bus.header_ack = 1'b0;
        checkOutput("ack_ready_low", 32'(bus.header_ready), 32'd0);
        checkOutput("ack_count_zero", 32'(bus.byte_count), 32'd0);
    endtask

    initial begin
        int mark;
        int base;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.header_ack = 1'b0;
        waitCycles(3);
        rst = 1'b0;
        checkOutput("rst_rx_ready",  32'(bus.rx_ready), 32'd0);
        checkOutput("rst_data_en",   32'(bus.o_data_en), 32'd0);
        checkOutput("rst_data",      32'(bus.o_data), 32'd0);
        checkOutput("rst_sel",       32'(bus.o_data_sel), 32'd0);
        checkOutput("rst_count",     32'(bus.byte_count), 32'd0);
        checkOutput("rst_ready",     32'(bus.header_ready), 32'd0);
        checkOutput("rst_error",     32'(bus.load_error), 32'd0);

        // Valid data in IDLE must be refused.
        mark = strobe_n;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        waitCycles(5);
        #1;
        checkOutput("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("idle_strobes",  32'(strobe_n - mark), 32'd0);
        bus.rx_valid = 1'b0;

        loadFullFrame(1'b0);

        // start while DONE must not disturb the loaded header.
        mark = strobe_n;
        pulseStart();
        bus.rx_valid = 1'b1;
        waitCycles(3);
        #1;
        checkOutput("done_start_ready",  32'(bus.header_ready), 32'd1);
        checkOutput("done_start_rxrdy",  32'(bus.rx_ready), 32'd0);
        checkOutput("done_start_count",  32'(bus.byte_count), 32'd80);
        checkOutput("done_start_strobe", 32'(strobe_n - mark), 32'd0);
        bus.rx_valid = 1'b0;
        ackHeader();
        bus.rx_valid = 1'b1;
        waitCycles(2);
        #1;
        checkOutput("ack_back_idle", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b0;

        loadFullFrame(1'b1);
        ackHeader();

        // Stall after 10 bytes until the frame times out.
        base = strobe_n;
        pulseStart();
        sendBytes(0, 10, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        waitCycles(1000);
        checkOutput("stall_no_error_yet", 32'(bus.load_error), 32'd0);
        checkOutput("stall_still_ready",  32'(bus.rx_ready), 32'd1);
        waitCycles(30);
        checkOutput("timeout_error",    32'(bus.load_error), 32'd1);
        checkOutput("timeout_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("timeout_count",    32'(bus.byte_count), 32'd10);
        bus.rx_valid = 1'b1;
        waitCycles(5);
        checkOutput("timeout_strobes", 32'(strobe_n - base), 32'd10);
        checkFrame(base, 0, 10);
        bus.rx_valid = 1'b0;
        pulseStart();
        checkOutput("restart_error_clr", 32'(bus.load_error), 32'd0);
        checkOutput("restart_count_clr", 32'(bus.byte_count), 32'd0);
        loadFullFrame(1'b0);
        ackHeader();

        // Restart mid-frame with start and rx_valid together.
        base = strobe_n;
        pulseStart();
        sendBytes(0, 30, 1'b0);
        @(negedge clk);
        checkOutput("mid_count30", 32'(bus.byte_count), 32'd30);
        bus.start    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        #1;
        checkOutput("restart_rx_ready", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("restart_no_strobe", 32'(bus.o_data_en), 32'd0);
        checkOutput("restart_count0",    32'(bus.byte_count), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("restart_first_en",   32'(bus.o_data_en), 32'd1);
        checkOutput("restart_first_sel",  32'(bus.o_data_sel), 32'd0);
        checkOutput("restart_first_data", 32'(bus.o_data), 32'h55);
        sendBytes(1, 39, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_count", 32'(bus.byte_count), 32'd40);
        checkOutput("restart_strobes", 32'(strobe_n - base), 32'd70);
        checkFrame(base + 31, 1, 39);

        // Reset during LOAD with a byte still being offered.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mark = strobe_n;
        checkOutput("mid_rst_data_en", 32'(bus.o_data_en), 32'd0);
        checkOutput("mid_rst_data",    32'(bus.o_data), 32'd0);
        checkOutput("mid_rst_sel",     32'(bus.o_data_sel), 32'd0);
        checkOutput("mid_rst_count",   32'(bus.byte_count), 32'd0);
        checkOutput("mid_rst_ready",   32'(bus.header_ready), 32'd0);
        checkOutput("mid_rst_error",   32'(bus.load_error), 32'd0);
        checkOutput("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("mid_rst_strobes", 32'(strobe_n - base), 32'd70);
        waitCycles(5);
        checkOutput("post_rst_strobes", 32'(strobe_n - mark), 32'd0);
        bus.rx_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
